// File: rtl/mult_accum_if.sv
// Handshake bundle between the product source, the accumulate stage and the
// sum consumer. The stage uses the slave modport; whatever drives products
// and takes sums uses the master modport.
interface mult_accum_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
);
    logic              clear;
    logic [CNT_W-1:0]  len;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              prod_ready;
    logic              sum_valid;
    logic [ACC_W-1:0]  sum;
    logic              sum_ready;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output clear, len, prod_valid, prod, sum_ready,
        input  prod_ready, sum_valid, sum, overflow, count
    );

    modport slave (
        input  clear, len, prod_valid, prod, sum_ready,
        output prod_ready, sum_valid, sum, overflow, count
    );
endinterface

// File: rtl/mult_accum_stage.sv
// Multiply-accumulate tail: sums a programmable number of unsigned products
// into one wide result and holds it on a valid/ready port until taken.
module mult_accum_stage #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    mult_accum_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic               ovf_reg, ovf_next;

    logic               accept;
    logic               handoff;
    logic [CNT_W-1:0]   len_eff;
    logic [CNT_W-1:0]   count_inc;
    logic [ACC_W:0]     acc_sum;

    // Ready is withheld while a finished sum waits, and while reset is held.
    assign bus.prod_ready = (state_reg != HOLD) && !rst;
    assign accept         = bus.prod_valid && bus.prod_ready;
    assign handoff        = (state_reg == HOLD) && bus.sum_ready;

    // A programmed length of zero is treated as a single-product sum.
    assign len_eff   = (bus.len == '0) ? CNT_W'(1) : bus.len;
    assign count_inc = count_reg + CNT_W'(1);
    // One extra bit catches the carry out of the accumulator width.
    assign acc_sum   = {1'b0, acc_reg} + (ACC_W+1)'(bus.prod);

    assign bus.sum_valid = (state_reg == HOLD);
    assign bus.sum       = acc_reg;
    assign bus.overflow  = ovf_reg;
    assign bus.count     = count_reg;

    // State and datapath registers; async reset returns everything to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            len_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state and datapath update; clear overrides any accept or handoff.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        len_next   = len_reg;
        ovf_next   = ovf_reg;

        if (bus.clear) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        len_next   = len_eff;
                        acc_next   = ACC_W'(bus.prod);
                        count_next = CNT_W'(1);
                        ovf_next   = 1'b0;
                        state_next = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_next   = acc_sum[ACC_W-1:0];
                        ovf_next   = ovf_reg | acc_sum[ACC_W];
                        count_next = count_inc;
                        if (count_inc == len_reg)
                            state_next = HOLD;
                    end
                end
                HOLD: begin
                    // Sum and overflow stay put; only the count is retired.
                    if (handoff) begin
                        state_next = IDLE;
                        count_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_accum_stage.sv
// Self-checking bench for mult_accum_stage: directed scenarios plus random
// traffic against a sum-of-products reference model.
module tb_mult_accum_stage;
    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    mult_accum_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) bus_a ();
    mult_accum_if #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) bus_b ();

    mult_accum_stage #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mult_accum_stage #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for dut_a: the true (unbounded) total of the products
    // accepted into the current sum, how many were taken, the length target
    // and whether a finished sum is waiting.
    logic [63:0] m_total;
    int          m_count;
    int          m_len;
    bit          m_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic model_reset();
        m_total = '0;
        m_count = 0;
        m_len   = 1;
        m_hold  = 0;
    endtask

    // One clock of dut_a with its inputs already set: checks ready before the
    // edge, advances the model, then compares all outputs after the edge.
    task automatic step();
        bit          c_clear, c_acc, c_hand;
        logic [31:0] c_prod;
        int          c_len;
        check("prod_ready", 64'(bus_a.prod_ready), 64'(!m_hold));
        c_clear = bus_a.clear;
        c_acc   = bus_a.prod_valid && !m_hold && !c_clear;
        c_hand  = m_hold && bus_a.sum_ready && !c_clear;
        c_prod  = bus_a.prod;
        c_len   = (bus_a.len == 0) ? 1 : int'(bus_a.len);
        @(posedge clk);
        #1;
        if (c_clear) begin
            m_total = '0;
            m_count = 0;
            m_hold  = 0;
        end else if (c_acc) begin
            if (m_count == 0) begin
                m_len   = c_len;
                m_total = 64'(c_prod);
            end else begin
                m_total = m_total + 64'(c_prod);
            end
            m_count++;
            if (m_count == m_len) m_hold = 1;
        end else if (c_hand) begin
            m_hold  = 0;
            m_count = 0;
        end
        check("sum_valid", 64'(bus_a.sum_valid), 64'(m_hold));
        check("count", 64'(bus_a.count), 64'(m_count));
        check("sum", 64'(bus_a.sum), {24'd0, m_total[39:0]});
        check("overflow", 64'(bus_a.overflow), 64'(|m_total[63:40]));
    endtask

    task automatic drive_a(input bit v, input logic [31:0] p, input logic [7:0] l,
                           input bit sr, input bit clr);
        bus_a.prod_valid = v;
        bus_a.prod       = p;
        bus_a.len        = l;
        bus_a.sum_ready  = sr;
        bus_a.clear      = clr;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst = 1'b1;
        drive_a(0, 0, 0, 0, 0);
        bus_b.prod_valid = 0;
        bus_b.prod       = 0;
        bus_b.len        = 0;
        bus_b.sum_ready  = 0;
        bus_b.clear      = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_prod_ready", 64'(bus_a.prod_ready), 64'd0);
        check("rst_sum_valid", 64'(bus_a.sum_valid), 64'd0);
        check("rst_sum", 64'(bus_a.sum), 64'd0);
        check("rst_count", 64'(bus_a.count), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_prod_ready", 64'(bus_a.prod_ready), 64'd1);
        @(posedge clk);
        #1;

        // T1: len=2, products 28 and 25 back to back
        drive_a(1, 28, 2, 0, 0); step();
        drive_a(1, 25, 2, 0, 0); step();
        check("t1_sum", 64'(bus_a.sum), 64'd53);
        check("t1_count", 64'(bus_a.count), 64'd2);

        // T3: backpressure for 3 cycles while 99 is offered
        drive_a(1, 99, 2, 0, 0);
        repeat (3) step();
        check("t3_held_sum", 64'(bus_a.sum), 64'd53);
        drive_a(1, 99, 2, 1, 0); step();   // handoff cycle, no accept
        drive_a(1, 99, 2, 0, 0); step();   // 99 taken here
        check("t3_count", 64'(bus_a.count), 64'd1);
        drive_a(1, 1, 2, 0, 0); step();
        check("t3_sum", 64'(bus_a.sum), 64'd100);
        drive_a(0, 0, 2, 1, 0); step();

        // T2: len=0 behaves as len=1
        drive_a(1, 28, 0, 0, 0); step();
        check("t2_sum", 64'(bus_a.sum), 64'd28);
        check("t2_valid", 64'(bus_a.sum_valid), 64'd1);
        drive_a(0, 0, 0, 1, 0); step();

        // T5: clear drops a partial sum
        drive_a(1, 28, 3, 0, 0); step();
        drive_a(1, 7, 3, 0, 1); step();    // product during clear is dropped
        check("t5_clr_count", 64'(bus_a.count), 64'd0);
        drive_a(1, 5, 2, 0, 0); step();
        drive_a(1, 5, 2, 0, 0); step();
        check("t5_sum", 64'(bus_a.sum), 64'd10);
        drive_a(0, 0, 2, 1, 0); step();
        drive_a(0, 0, 2, 0, 0);

        // T4: 33-bit accumulator overflows on 3 x 0xFFFFFFFF
        bus_b.len        = 3;
        bus_b.prod       = 32'hFFFF_FFFF;
        bus_b.prod_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        bus_b.prod_valid = 0;
        check("t4_valid", 64'(bus_b.sum_valid), 64'd1);
        check("t4_sum", 64'(bus_b.sum), 64'h0_FFFF_FFFD);
        check("t4_ovf", 64'(bus_b.overflow), 64'd1);
        bus_b.sum_ready = 1;
        @(posedge clk);
        #1;
        bus_b.sum_ready  = 0;
        bus_b.len        = 1;
        bus_b.prod       = 5;
        bus_b.prod_valid = 1;
        @(posedge clk);
        #1;
        bus_b.prod_valid = 0;
        check("t4_sum2", 64'(bus_b.sum), 64'd5);
        check("t4_ovf2", 64'(bus_b.overflow), 64'd0);
        bus_b.sum_ready = 1;
        @(posedge clk);
        #1;
        bus_b.sum_ready = 0;

        // T6: async reset while a sum of 53 is held
        drive_a(1, 28, 2, 0, 0); step();
        drive_a(1, 25, 2, 0, 0); step();
        drive_a(0, 0, 2, 0, 0);
        #3 rst = 1'b1;
        #1;
        check("t6_valid", 64'(bus_a.sum_valid), 64'd0);
        check("t6_sum", 64'(bus_a.sum), 64'd0);
        check("t6_ready", 64'(bus_a.prod_ready), 64'd0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        drive_a(1, 25, 1, 0, 0); step();
        check("t6_sum2", 64'(bus_a.sum), 64'd25);
        drive_a(0, 0, 1, 1, 0); step();

        // Random traffic: bubbles, backpressure, occasional clear
        for (int i = 0; i < 400; i++) begin
            drive_a($urandom_range(0, 3) != 0, $urandom(), 8'($urandom_range(0, 6)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
